// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the codec DAC serializer.
//   DEF_DATA_W    - default sample width per channel
//   DEF_SLOT_W    - default BCLK periods per channel slot (>= DATA_W+1)
//   DEF_BCLK_HALF - default clk cycles per BCLK half-period (>= 2)
//   slot_t        - which channel slot the LR clock is signalling
//   stereo_t      - one stereo sample pair at the default width
package audio_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SLOT_W    = 32;
  localparam int DEF_BCLK_HALF = 4;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// audio_bclk_gen: divides clk down to the codec bit clock.
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   enable in   low holds the divider and BCLK at their reset values
//   bclk   out  registered bit clock, low after reset/enable
//   fall   out  high in the cycle whose clock edge drives BCLK high->low
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap = (div == DIV_LAST);
  // Strobe is combinational so the top can act on the same edge BCLK falls.
  assign fall = enable && bclk && wrap;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: I2S transmit master for the codec DAC port.
//   clk, reset            system clock, synchronous active-high reset
//   enable                run the serial port; low parks pins at 0
//   sample_left/right     stereo pair, two's complement
//   sample_valid/ready    handshake into a one-entry holding buffer
//   underrun              one-cycle pulse when a frame starts with no data
//   AUD_BCLK              bit clock
//   AUD_DACLRCK           0 = left slot, 1 = right slot
//   AUD_DACDAT            serial data, MSB first, one BCLK after LRCK edge
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOT_W    = DEF_SLOT_W,
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              underrun,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT
);

  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [BIT_W-1:0] B_LAST    = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] B_ONE     = BIT_W'(1);
  localparam logic [BIT_W-1:0] B_LEND    = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] B_RSTART  = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] B_RFIRST  = BIT_W'(SLOT_W + 1);
  localparam logic [BIT_W-1:0] B_REND    = BIT_W'(SLOT_W + DATA_W);

  logic                  fall;
  logic                  running;
  logic [BIT_W-1:0]      bit_idx;
  logic [BIT_W-1:0]      b_next;
  logic                  load;
  logic                  in_data;
  logic                  accept;
  logic                  hold_full;
  logic [2*DATA_W-1:0]   hold;
  logic [2*DATA_W-1:0]   shreg;
  slot_t                 lrck;
  logic                  dat;

  audio_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bclk  (AUD_BCLK),
    .fall  (fall)
  );

  // The first fall strobe after reset/enable starts the frame at b=0
  // rather than advancing the idle index.
  always_comb begin
    b_next = '0;
    if (running && (bit_idx != B_LAST)) b_next = bit_idx + 1'b1;
  end

  assign load    = fall && (b_next == '0);
  assign in_data = ((b_next >= B_ONE)    && (b_next <= B_LEND)) ||
                   ((b_next >= B_RFIRST) && (b_next <= B_REND));
  assign accept  = sample_valid && !hold_full;

  assign sample_ready = !hold_full;
  assign AUD_DACLRCK  = lrck;
  assign AUD_DACDAT   = dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold      <= '0;
      shreg     <= '0;
      running   <= 1'b0;
      bit_idx   <= '0;
      lrck      <= SLOT_LEFT;
      dat       <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // Load drains the buffer; an accept in the same cycle is only possible
      // when it was already empty, so the new pair waits for the next frame.
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold      <= {sample_left, sample_right};
      end

      if (!enable) begin
        running <= 1'b0;
        bit_idx <= '0;
        lrck    <= SLOT_LEFT;
        dat     <= 1'b0;
        shreg   <= '0;
      end else if (fall) begin
        running <= 1'b1;
        bit_idx <= b_next;
        lrck    <= (b_next >= B_RSTART) ? SLOT_RIGHT : SLOT_LEFT;
        if (load) begin
          shreg    <= hold_full ? hold : '0;
          underrun <= !hold_full;
          dat      <= 1'b0;
        end else if (in_data) begin
          // Left then right MSBs come off the top in order.
          dat   <= shreg[2*DATA_W-1];
          shreg <= {shreg[2*DATA_W-2:0], 1'b0};
        end else begin
          dat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        underrun;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  localparam logic [63:0] LR_MASK = 64'hFFFF_FFFF_0000_0000;

  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   stream_n = 0;
  bit   stream = 1'b0;
  logic prev_ready;

  logic [63:0] db, lb;
  int          urs, rises, tog, acc0;

  audio_dac_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .underrun    (underrun),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // I2S frame: left MSB at b=1..16, right MSB at b=33..48, rest 0.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int k = 1; k <= 16; k++) begin
      f[k]      = l[16-k];
      f[32 + k] = r[16-k];
    end
    return f;
  endfunction

  task automatic step();
    logic acc;
    acc = sample_valid && sample_ready;
    prev_ready = sample_ready;
    @(posedge clk);
    #1;
    if (acc === 1'b1) begin
      n_acc++;
      if (stream) begin
        stream_n++;
        sample_left  = 16'h1000 + stream_n[15:0];
        sample_right = 16'h2000 + stream_n[15:0];
      end else begin
        sample_valid = 1'b0;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int start;
    int guard;
    start = n_acc;
    guard = 0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    while (n_acc == start && guard < 1100) begin
      step();
      guard++;
    end
    chk("push_accepted", 64'(n_acc - start), 64'd1);
  endtask

  // Called right after a frame-load edge; records one 512-cycle frame.
  task automatic cap(output logic [63:0] dbits, output logic [63:0] lbits,
                     output int u, output int rr, output int tg);
    logic pb;
    dbits = '0;
    lbits = '0;
    u = 0;
    rr = 0;
    tg = 0;
    for (int i = 0; i < 512; i++) begin
      if (i % 8 == 0) begin
        dbits[i/8] = AUD_DACDAT;
        lbits[i/8] = AUD_DACLRCK;
      end
      if (underrun === 1'b1) u++;
      if (sample_ready === 1'b1 && prev_ready === 1'b0) rr++;
      pb = AUD_BCLK;
      step();
      if (AUD_BCLK !== pb) tg++;
    end
  endtask

  initial begin
    // ---- reset, idle running, no samples
    enable = 1'b1;
    do_reset();
    chk("reset_pins", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_ready, underrun}, 5'b00010);
    steps(3);
    chk("bclk_c3", AUD_BCLK, 1'b0);
    step();
    chk("bclk_rise_c4", AUD_BCLK, 1'b1);
    steps(3);
    chk("no_ur_c7", {AUD_BCLK, underrun}, 2'b10);
    step();
    chk("first_fall_c8", {AUD_BCLK, AUD_DACLRCK, underrun}, 3'b001);
    cap(db, lb, urs, rises, tog);
    chk("idle_dat", db, 64'd0);
    chk("idle_lrck", lb, LR_MASK);
    chk("idle_ur_count", 64'(urs), 64'd1);
    chk("idle_bclk_toggles", 64'(tog), 64'd128);
    chk("idle_ur_next_frame", underrun, 1'b1);

    // ---- one pair pushed before the first frame
    do_reset();
    push(16'hA5C3, 16'h0F01);
    chk("ready_low_after_accept", sample_ready, 1'b0);
    steps(7);
    chk("load_b_ur_ready", {underrun, sample_ready}, 2'b01);
    cap(db, lb, urs, rises, tog);
    chk("pairB_dat", db, exp_frame(16'hA5C3, 16'h0F01));
    chk("pairB_lrck", lb, LR_MASK);
    chk("pairB_ur", 64'(urs), 64'd0);

    // ---- continuous valid with incrementing data
    do_reset();
    stream = 1'b1;
    stream_n = 0;
    sample_left  = 16'h1000;
    sample_right = 16'h2000;
    sample_valid = 1'b1;
    steps(8);
    chk("stream_first_load_ur", underrun, 1'b0);
    for (int f = 0; f < 3; f++) begin
      cap(db, lb, urs, rises, tog);
      chk("stream_dat", db, exp_frame(16'h1000 + 16'(f), 16'h2000 + 16'(f)));
      chk("stream_ur", 64'(urs), 64'd0);
      chk("stream_ready_rises", 64'(rises), 64'd1);
    end
    stream = 1'b0;
    sample_valid = 1'b0;

    // ---- valid arrives on the frame-load edge with buffer empty
    do_reset();
    steps(7);
    sample_left  = 16'h1234;
    sample_right = 16'hABCD;
    sample_valid = 1'b1;
    step();
    chk("coincident_ur_ready", {underrun, sample_ready}, 2'b10);
    cap(db, lb, urs, rises, tog);
    chk("coincident_zero_frame", db, 64'd0);
    chk("coincident_ur_count", 64'(urs), 64'd1);
    cap(db, lb, urs, rises, tog);
    chk("coincident_next_frame", db, exp_frame(16'h1234, 16'hABCD));
    chk("coincident_next_ur", 64'(urs), 64'd0);

    // ---- enable dropped mid right slot for 100 clk
    push(16'h8001, 16'h7FFE);
    steps(299);
    chk("pre_disable_pins", {AUD_BCLK, AUD_DACLRCK}, 2'b11);
    enable = 1'b0;
    step();
    chk("disable_pins", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_ready}, 4'b0000);
    acc0 = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (underrun === 1'b1 || AUD_BCLK !== 1'b0) acc0++;
    end
    chk("disabled_quiet", 64'(acc0), 64'd0);
    enable = 1'b1;
    steps(3);
    chk("reen_bclk_c3", AUD_BCLK, 1'b0);
    step();
    chk("reen_bclk_c4", AUD_BCLK, 1'b1);
    steps(4);
    chk("reen_load_c8", {AUD_BCLK, AUD_DACLRCK, underrun, sample_ready}, 4'b0001);
    cap(db, lb, urs, rises, tog);
    chk("reen_frame", db, exp_frame(16'h8001, 16'h7FFE));
    chk("reen_ur", 64'(urs), 64'd0);

    // ---- reset mid-frame with holding full
    push(16'hDEAD, 16'hBEEF);
    steps(100);
    chk("hold_full_ready", sample_ready, 1'b0);
    reset = 1'b1;
    step();
    chk("midreset_pins", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_ready, underrun}, 5'b00010);
    reset = 1'b0;
    steps(8);
    chk("after_reset_ur", underrun, 1'b1);
    cap(db, lb, urs, rises, tog);
    chk("discarded_frame", db, 64'd0);
    chk("discarded_lrck", lb, LR_MASK);
    chk("discarded_ur", 64'(urs), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
